// File: rtl/pc_redirect_ctrl.sv
// PC redirect / pipeline flush controller for the RV32I resolve stage.
// Optional event counters are enabled by defining PC_REDIRECT_PERF_EN.
module pc_redirect_ctrl #(
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        resolve_valid,
  input  logic        branch_taken,
  input  logic [4:0]  opcode,
  input  logic [31:0] resolve_pc,
  input  logic [31:0] target_addr,
  input  logic [31:0] alu_result,
  input  logic        stall,
  output logic        pc_sel,
  output logic [31:0] redirect_pc,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        flush_ex_mem,
  output logic        flush_mem_wb,
  output logic        misaligned_exc,
`ifdef PC_REDIRECT_PERF_EN
  output logic [31:0] perf_redirects,
  output logic [31:0] perf_traps,
`endif
  output logic [31:0] trap_epc
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_TRAP     = 2'd2
  } state_t;

  localparam logic [4:0] OPC_JALR = 5'b11001;

  // JALR clears bit 0 of rs1+imm; branches and JAL already produce an even target
  function automatic logic [31:0] f_target(input logic [4:0]  op,
                                           input logic [31:0] alu,
                                           input logic [31:0] tgt);
    logic [31:0] t;
    if (op == OPC_JALR) begin
      t = alu & 32'hFFFF_FFFE;
    end else begin
      t = tgt;
    end
    return t;
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_redirect_pc;
  logic [31:0] w_redirect_pc_nxt;
  logic [31:0] r_trap_epc;
  logic [31:0] w_trap_epc_nxt;
  logic        r_pc_sel;
  logic        r_flush_front;
  logic        r_flush_mem_wb;
  logic        r_misaligned;
  logic        w_event;
  logic [31:0] w_target;
  logic        w_misaligned;

  // Decode the resolve-stage decision into an event and its final target
  always_comb begin
    w_event      = resolve_valid & branch_taken;
    w_target     = f_target(opcode, alu_result, target_addr);
    w_misaligned = w_target[1];
  end

  // Next-state and next-register logic; REDIRECT/TRAP ignore the wrong-path resolve stage
  always_comb begin
    w_state_nxt       = r_state;
    w_redirect_pc_nxt = r_redirect_pc;
    w_trap_epc_nxt    = r_trap_epc;
    case (r_state)
      ST_IDLE: begin
        if (!stall && w_event) begin
          if (w_misaligned) begin
            w_state_nxt       = ST_TRAP;
            w_redirect_pc_nxt = TRAP_VECTOR;
            w_trap_epc_nxt    = resolve_pc;
          end else begin
            w_state_nxt       = ST_REDIRECT;
            w_redirect_pc_nxt = w_target;
            w_trap_epc_nxt    = 32'h0000_0000;
          end
        end else begin
          w_state_nxt       = ST_IDLE;
          w_redirect_pc_nxt = 32'h0000_0000;
          w_trap_epc_nxt    = 32'h0000_0000;
        end
      end
      ST_REDIRECT, ST_TRAP: begin
        if (!stall) begin
          w_state_nxt       = ST_IDLE;
          w_redirect_pc_nxt = 32'h0000_0000;
          w_trap_epc_nxt    = 32'h0000_0000;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt       = ST_IDLE;
        w_redirect_pc_nxt = 32'h0000_0000;
        w_trap_epc_nxt    = 32'h0000_0000;
      end
    endcase
  end

  // State and output registers; outputs are decoded from the next state so they are flop outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_redirect_pc  <= 32'h0000_0000;
      r_trap_epc     <= 32'h0000_0000;
      r_pc_sel       <= 1'b0;
      r_flush_front  <= 1'b0;
      r_flush_mem_wb <= 1'b0;
      r_misaligned   <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_redirect_pc  <= w_redirect_pc_nxt;
      r_trap_epc     <= w_trap_epc_nxt;
      r_pc_sel       <= (w_state_nxt != ST_IDLE);
      r_flush_front  <= (w_state_nxt != ST_IDLE);
      r_flush_mem_wb <= (w_state_nxt == ST_TRAP);
      r_misaligned   <= (w_state_nxt == ST_TRAP);
    end
  end

`ifdef PC_REDIRECT_PERF_EN
  logic [31:0] r_perf_redirects;
  logic [31:0] r_perf_traps;

  // Count accepted redirects and traps (wrap naturally at 2^32)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_redirects <= 32'h0000_0000;
      r_perf_traps     <= 32'h0000_0000;
    end else begin
      if ((r_state == ST_IDLE) && (w_state_nxt == ST_REDIRECT)) begin
        r_perf_redirects <= r_perf_redirects + 32'h0000_0001;
      end
      if ((r_state == ST_IDLE) && (w_state_nxt == ST_TRAP)) begin
        r_perf_traps <= r_perf_traps + 32'h0000_0001;
      end
    end
  end

  assign perf_redirects = r_perf_redirects;
  assign perf_traps     = r_perf_traps;
`endif

  assign pc_sel         = r_pc_sel;
  assign redirect_pc    = r_redirect_pc;
  assign flush_if_id    = r_flush_front;
  assign flush_id_ex    = r_flush_front;
  assign flush_ex_mem   = r_flush_front;
  assign flush_mem_wb   = r_flush_mem_wb;
  assign misaligned_exc = r_misaligned;
  assign trap_epc       = r_trap_epc;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed scoreboard bench for pc_redirect_ctrl; counter checks only when PC_REDIRECT_PERF_EN is defined.
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        resolve_valid;
  logic        branch_taken;
  logic [4:0]  opcode;
  logic [31:0] resolve_pc;
  logic [31:0] target_addr;
  logic [31:0] alu_result;
  logic        stall;
  logic        pc_sel;
  logic [31:0] redirect_pc;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        flush_ex_mem;
  logic        flush_mem_wb;
  logic        misaligned_exc;
  logic [31:0] trap_epc;
`ifdef PC_REDIRECT_PERF_EN
  logic [31:0] perf_redirects;
  logic [31:0] perf_traps;
`endif

  int total = 0;
  int bad   = 0;
  logic [69:0] sb[$];
  logic [69:0] obs;

  pc_redirect_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .resolve_valid  (resolve_valid),
    .branch_taken   (branch_taken),
    .opcode         (opcode),
    .resolve_pc     (resolve_pc),
    .target_addr    (target_addr),
    .alu_result     (alu_result),
    .stall          (stall),
    .pc_sel         (pc_sel),
    .redirect_pc    (redirect_pc),
    .flush_if_id    (flush_if_id),
    .flush_id_ex    (flush_id_ex),
    .flush_ex_mem   (flush_ex_mem),
    .flush_mem_wb   (flush_mem_wb),
    .misaligned_exc (misaligned_exc),
`ifdef PC_REDIRECT_PERF_EN
    .perf_redirects (perf_redirects),
    .perf_traps     (perf_traps),
`endif
    .trap_epc       (trap_epc)
  );

  always #5 clk = ~clk;

  assign obs = {pc_sel, flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
                misaligned_exc, redirect_pc, trap_epc};

  // Expected output vectors: {pc_sel, 4 flushes, misaligned_exc, redirect_pc, trap_epc}
  function automatic logic [69:0] e_idle();
    return 70'd0;
  endfunction

  function automatic logic [69:0] e_redir(input logic [31:0] pc);
    return {6'b111100, pc, 32'h0000_0000};
  endfunction

  function automatic logic [69:0] e_trap(input logic [31:0] epc);
    return {6'b111111, 32'h0000_0100, epc};
  endfunction

  task automatic drive(input logic r, input logic rv, input logic bt, input logic [4:0] op,
                       input logic [31:0] rpc, input logic [31:0] tgt,
                       input logic [31:0] alu, input logic st);
    rst           = r;
    resolve_valid = rv;
    branch_taken  = bt;
    opcode        = op;
    resolve_pc    = rpc;
    target_addr   = tgt;
    alu_result    = alu;
    stall         = st;
  endtask

  task automatic tick(input logic [69:0] e, input string tag);
    logic [69:0] exp_v;
    sb.push_back(e);
    @(posedge clk);
    #1;
    exp_v = sb.pop_front();
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, 1'b0, 5'b00000, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // reset wins over a live event
    drive(1'b1, 1'b1, 1'b1, 5'b11000, 32'h0000_0020, 32'h0000_0040, 32'h0, 1'b0);
    tick(e_idle(), "reset_state");
    idle_inputs();
    tick(e_idle(), "idle_no_event");

    // BEQ taken: one-cycle redirect then clear
    drive(1'b0, 1'b1, 1'b1, 5'b11000, 32'h0000_0020, 32'h0000_0040, 32'h0, 1'b0);
    tick(e_redir(32'h0000_0040), "beq_redirect");
    idle_inputs();
    tick(e_idle(), "beq_clear");

    // not-taken and bubble cases
    drive(1'b0, 1'b1, 1'b0, 5'b11000, 32'h0000_0020, 32'h0000_0040, 32'h0, 1'b0);
    tick(e_idle(), "not_taken");
    drive(1'b0, 1'b0, 1'b1, 5'b11000, 32'h0000_0020, 32'h0000_0040, 32'h0, 1'b0);
    tick(e_idle(), "bubble");

    // JALR clears bit 0 of rs1+imm
    drive(1'b0, 1'b1, 1'b1, 5'b11001, 32'h0000_0030, 32'h0000_9990, 32'h0000_1235, 1'b0);
    tick(e_redir(32'h0000_1234), "jalr_bit0");
    idle_inputs();
    tick(e_idle(), "jalr_clear");

    // JALR with bit 1 set traps
    drive(1'b0, 1'b1, 1'b1, 5'b11001, 32'h0000_0034, 32'h0000_0000, 32'h0000_1237, 1'b0);
    tick(e_trap(32'h0000_0034), "jalr_misaligned");
    idle_inputs();
    tick(e_idle(), "jalr_trap_clear");

    // JAL misaligned target
    drive(1'b0, 1'b1, 1'b1, 5'b11011, 32'h0000_0010, 32'h0000_0042, 32'h0, 1'b0);
    tick(e_trap(32'h0000_0010), "jal_misaligned");
    idle_inputs();
    tick(e_idle(), "jal_trap_clear");

    // non-control opcode with branch_taken still redirects
    drive(1'b0, 1'b1, 1'b1, 5'b01100, 32'h0000_0050, 32'h0000_0a00, 32'h0, 1'b0);
    tick(e_redir(32'h0000_0a00), "nonctrl_redirect");
    idle_inputs();
    tick(e_idle(), "nonctrl_clear");

    // stall for three cycles during REDIRECT extends it
    drive(1'b0, 1'b1, 1'b1, 5'b11000, 32'h0000_0060, 32'h0000_0080, 32'h0, 1'b0);
    tick(e_redir(32'h0000_0080), "stall_n1");
    stall = 1'b1;
    tick(e_redir(32'h0000_0080), "stall_n2");
    tick(e_redir(32'h0000_0080), "stall_n3");
    tick(e_redir(32'h0000_0080), "stall_n4");
    stall = 1'b0;
    tick(e_idle(), "stall_n5_clear");
    idle_inputs();
    tick(e_idle(), "stall_after");

    // event presented under stall in IDLE is not sampled until stall drops
    drive(1'b0, 1'b1, 1'b1, 5'b11011, 32'h0000_0070, 32'h0000_0200, 32'h0, 1'b1);
    tick(e_idle(), "idle_stall_a");
    tick(e_idle(), "idle_stall_b");
    stall = 1'b0;
    tick(e_redir(32'h0000_0200), "idle_stall_release");
    idle_inputs();
    tick(e_idle(), "idle_stall_clear");

    // stall holds a TRAP as well
    drive(1'b0, 1'b1, 1'b1, 5'b11000, 32'h0000_0074, 32'h0000_0306, 32'h0, 1'b0);
    tick(e_trap(32'h0000_0074), "trap_stall_1");
    drive(1'b0, 1'b1, 1'b1, 5'b11000, 32'h0000_0078, 32'h0000_0400, 32'h0, 1'b1);
    tick(e_trap(32'h0000_0074), "trap_stall_2");
    idle_inputs();
    tick(e_idle(), "trap_stall_clear");

    // wrong-path guard: branch_taken held high gives 1,0,1,0
    drive(1'b0, 1'b1, 1'b1, 5'b11000, 32'h0000_0080, 32'h0000_0500, 32'h0, 1'b0);
    tick(e_redir(32'h0000_0500), "wrongpath_1");
    tick(e_idle(), "wrongpath_0a");
    tick(e_redir(32'h0000_0500), "wrongpath_1b");
    tick(e_idle(), "wrongpath_0b");
    tick(e_redir(32'h0000_0500), "wrongpath_1c");
    // reset while in REDIRECT
    rst = 1'b1;
    tick(e_idle(), "reset_in_redirect");
    idle_inputs();
    tick(e_idle(), "post_reset_idle");
`ifdef PC_REDIRECT_PERF_EN
    total++;
    assert (perf_redirects === 32'd0 && perf_traps === 32'd0) else begin
      bad++;
      $error("FAIL perf_reset: observed=%h/%h expected=0/0", perf_redirects, perf_traps);
    end
`endif

    // three redirects and one trap after reset
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, 5'b11000, 32'h0000_0090, 32'h0000_0600 + 32'(i) * 32'h10, 32'h0, 1'b0);
      tick(e_redir(32'h0000_0600 + 32'(i) * 32'h10), "perf_seq_redirect");
      idle_inputs();
      tick(e_idle(), "perf_seq_clear");
    end
    drive(1'b0, 1'b1, 1'b1, 5'b11011, 32'h0000_00a0, 32'h0000_0702, 32'h0, 1'b0);
    tick(e_trap(32'h0000_00a0), "perf_seq_trap");
    idle_inputs();
    tick(e_idle(), "perf_seq_trap_clear");
`ifdef PC_REDIRECT_PERF_EN
    total++;
    assert (perf_redirects === 32'd3 && perf_traps === 32'd1) else begin
      bad++;
      $error("FAIL perf_count: observed=%h/%h expected=3/1", perf_redirects, perf_traps);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
